iir_filter_cfg: RTL
===================

Name: iir_filter_cfg

Overview:
- Parametrised successor to the fixed 8th-order IIR_filter.
- Direct-form-I IIR filter with configurable order, data width and coefficient width.
- Coefficients are written at run time through a shadow bank and committed atomically.
- Sits between the sample source and sink, using the existing DIN/VIN → DOUT/VOUT valid protocol.

Parameters:
- NB, 10, signed sample width (DIN, DOUT).
- NC, 12, signed coefficient width.
- ORDER, 8, filter order; taps b0..bORDER and a1..aORDER.
- FRAC, 9, coefficient fractional bits; a0 is implicitly 2^FRAC and is not stored.

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- DIN  in  NB  signed input sample.
- VIN  in  1  DIN valid; one sample per cycle while high.
- CLR  in  1  synchronous clear of the x/y delay lines.
- COEF_WE  in  1  shadow coefficient write strobe.
- COEF_SEL  in  1  0 = b bank, 1 = a bank.
- COEF_IDX  in  $clog2(ORDER+1)  tap index.
- COEF_DATA  in  NC  signed coefficient value.
- COEF_COMMIT  in  1  copy shadow bank to active bank.
- DOUT  out  NB  signed filtered sample.
- VOUT  out  1  DOUT valid, one-cycle pulse per accepted sample.

Behaviour:
- Reset (async, RST_n=0):
  - DOUT=0, VOUT=0.
  - x/y delay lines, shadow bank and active bank all = 0.
  - Reset mid-stream discards all state immediately.
- Per accepted sample (VIN=1 at edge t):
  - acc = Σ_{k=0..ORDER} b_k·x[n−k] − Σ_{k=1..ORDER} a_k·y[n−k], with x[n]=DIN.
  - Full precision, accumulator width NB+NC+$clog2(2·ORDER+1).
  - Round half-up: acc + 2^(FRAC−1), then arithmetic shift right by FRAC.
  - Reduce the result to NB bits (see Optional Feature).
- Latency and output timing:
  - DOUT is registered and VOUT=1 at edge t+1, i.e. 1-cycle latency.
  - When VIN=0, VOUT=0 next cycle, DOUT holds its last value and the delay lines do not shift.
  - Back-to-back VIN gives full throughput.
- Delay lines:
  - Shift only on VIN=1: x line takes DIN, y line takes the reduced output.
  - Out-of-range taps are never read.
- CLR:
  - Zeroes both delay lines at the edge; coefficients are untouched.
  - CLR with VIN in the same cycle: the sample is computed with zeroed history (x[n]=DIN, all older taps 0) and the output is produced normally.
- Coefficient writes:
  - COEF_WE writes shadow[COEF_SEL][COEF_IDX].
  - Writes to a0 (SEL=1, IDX=0) and to IDX>ORDER are ignored.
- Commit:
  - COEF_COMMIT copies the whole shadow bank to the active bank at the edge.
  - A write in the same cycle is included in the commit.
  - A sample accepted in the commit cycle uses the old active bank; new coefficients apply from the next accepted sample.
  - There is never a mixed old/new coefficient set.
- No state machine beyond the delay/valid pipeline; no backpressure, the sink must accept every VOUT.

Optional Feature:
- Macro IIR_SAT_EN.
- Defined: the result is saturated to [−2^(NB−1), 2^(NB−1)−1] both on DOUT and in the y delay line.
- Undefined: the low NB bits are kept (two's-complement wrap), saving a comparator.
- Rounding is identical in both builds.

Decomposition:
- Package iir_pkg holds:
  - default ORDER/NB/NC/FRAC;
  - an acc_width function;
  - the COEF_SEL_B / COEF_SEL_A constants;
  - the coefficient-array typedef.
- One sub-module, iir_round_sat: round, shift and reduce from accumulator width to NB. It is combinational and contains the IIR_SAT_EN choice.

Test Plan:
- Passthrough: commit b0=512, others 0; VIN with DIN=100, −37, 511 → VOUT next cycle each, DOUT=100, −37, 511.
- First-order feedback: b0=512, a1=−256; DIN=100 held for 4 valid samples → DOUT=100, 150, 175, 188.
- Valid gaps: same filter, VIN pattern 1,0,0,1 → second output is 150 (state frozen during gaps), VOUT only on the two cycles after VIN, DOUT held in between.
- Saturation: b0=1024, DIN=400 → DOUT=511 with IIR_SAT_EN, DOUT=−224 without.
- Atomic commit: run the passthrough filter; write b0=1024 with commit in the same cycle as VIN DIN=50 → DOUT=50; next DIN=50 → 100. An a0 write has no effect.
- Reset/CLR: assert RST_n=0 mid-stream → DOUT=0, VOUT=0 asynchronously and coefficients are zero. After reload of the first-order filter: a CLR+VIN cycle with DIN=100 yields 100, not a history-dependent value.

Source files
------------

// File: rtl/iir_pkg.sv
// ============================================================================
// Module      : iir_pkg
// Description : Shared defaults, constants, helper function and coefficient
//               array type for the configurable direct-form-I IIR filter.
// Contents    : NB_DEF/NC_DEF/ORDER_DEF/FRAC_DEF default sizes,
//               COEF_SEL_B/COEF_SEL_A bank selectors, acc_width(),
//               coef_arr_t (coefficient array at default sizes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iir_pkg;

    localparam int NB_DEF    = 10;
    localparam int NC_DEF    = 12;
    localparam int ORDER_DEF = 8;
    localparam int FRAC_DEF  = 9;

    localparam logic COEF_SEL_B = 1'b0;
    localparam logic COEF_SEL_A = 1'b1;

    // Enough headroom for 2*ORDER+1 full-precision products summed together.
    function automatic int acc_width(input int nb, input int nc, input int order);
        return nb + nc + $clog2(2 * order + 1);
    endfunction

    typedef logic signed [NC_DEF-1:0] coef_arr_t [0:ORDER_DEF];

endpackage

`default_nettype wire

// File: rtl/iir_filter_cfg_if.sv
// ============================================================================
// Module      : iir_filter_cfg_if
// Description : Sample stream and coefficient programming bundle for
//               iir_filter_cfg.
// Signals     : DIN/VIN      - input sample and its valid
//               CLR          - clear of the x/y delay lines
//               COEF_WE/SEL/IDX/DATA - shadow coefficient write
//               COEF_COMMIT  - copy shadow bank to active bank
//               DOUT/VOUT    - filtered sample and its valid pulse
// Modports    : master (sample source / programmer), slave (filter)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iir_filter_cfg_if
    import iir_pkg::*;
#(
    parameter int NB    = NB_DEF,
    parameter int NC    = NC_DEF,
    parameter int ORDER = ORDER_DEF
);
    localparam int IW = $clog2(ORDER + 1);

    logic signed [NB-1:0] DIN;
    logic                 VIN;
    logic                 CLR;
    logic                 COEF_WE;
    logic                 COEF_SEL;
    logic [IW-1:0]        COEF_IDX;
    logic signed [NC-1:0] COEF_DATA;
    logic                 COEF_COMMIT;
    logic signed [NB-1:0] DOUT;
    logic                 VOUT;

    modport master (
        output DIN, VIN, CLR, COEF_WE, COEF_SEL, COEF_IDX, COEF_DATA, COEF_COMMIT,
        input  DOUT, VOUT
    );

    modport slave (
        input  DIN, VIN, CLR, COEF_WE, COEF_SEL, COEF_IDX, COEF_DATA, COEF_COMMIT,
        output DOUT, VOUT
    );

endinterface

`default_nettype wire

// File: rtl/iir_round_sat.sv
// ============================================================================
// Module      : iir_round_sat
// Description : Combinational round-half-up, arithmetic shift by FRAC and
//               reduction of the accumulator to NB bits.
// Ports       : i_acc  (ACCW, signed) - full-precision accumulator
//               o_dout (NB, signed)   - reduced sample
// Config      : IIR_SAT_EN defined   -> saturate to the NB-bit signed range
//               IIR_SAT_EN undefined -> keep low NB bits (two's-complement wrap)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_round_sat #(
    parameter int NB   = 10,
    parameter int ACCW = 27,
    parameter int FRAC = 9
) (
    input  wire logic signed [ACCW-1:0] i_acc,
    output logic signed [NB-1:0]        o_dout
);

    localparam int SW = ACCW - FRAC;

    localparam logic signed [ACCW-1:0] C_HALF =
        {{(ACCW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    logic signed [ACCW-1:0] w_rnd;
    logic signed [SW-1:0]   w_sh;
    logic                   w_unused_bits;

    assign w_rnd = i_acc + C_HALF;
    // Dropping the low FRAC bits of a signed value is the arithmetic shift.
    assign w_sh  = w_rnd[ACCW-1:FRAC];

`ifdef IIR_SAT_EN
    localparam logic signed [SW-1:0] C_MAX = {{(SW-NB+1){1'b0}}, {(NB-1){1'b1}}};
    localparam logic signed [SW-1:0] C_MIN = {{(SW-NB+1){1'b1}}, {(NB-1){1'b0}}};

    always_comb begin
        o_dout = w_sh[NB-1:0];
        if (w_sh > C_MAX) begin
            o_dout = {1'b0, {(NB-1){1'b1}}};
        end else if (w_sh < C_MIN) begin
            o_dout = {1'b1, {(NB-1){1'b0}}};
        end
    end

    assign w_unused_bits = ^w_rnd[FRAC-1:0];
`else
    assign o_dout        = w_sh[NB-1:0];
    assign w_unused_bits = ^{w_sh[SW-1:NB], w_rnd[FRAC-1:0]};
`endif

endmodule

`default_nettype wire

// File: rtl/iir_filter_cfg.sv
// ============================================================================
// Module      : iir_filter_cfg
// Description : Direct-form-I IIR filter, configurable order and widths,
//               with a shadow coefficient bank committed atomically.
//               One-cycle latency, full throughput, no backpressure.
// Ports       : CLK   - clock, rising edge
//               RST_n - asynchronous active-low reset
//               bus   - iir_filter_cfg_if.slave (DIN/VIN, CLR, COEF_*,
//                       DOUT/VOUT)
// Config      : IIR_SAT_EN selects saturation (defined) or wrap (undefined)
//               of the result on DOUT and in the y delay line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_filter_cfg
    import iir_pkg::*;
#(
    parameter int NB    = NB_DEF,
    parameter int NC    = NC_DEF,
    parameter int ORDER = ORDER_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  wire logic        CLK,
    input  wire logic        RST_n,
    iir_filter_cfg_if.slave  bus
);

    localparam int ACCW = acc_width(NB, NC, ORDER);
    localparam int PW   = NB + NC;
    localparam int IW   = $clog2(ORDER + 1);

    // Delay lines: index k holds the sample k steps in the past.
    logic signed [NB-1:0] r_x [1:ORDER];
    logic signed [NB-1:0] r_y [1:ORDER];

    // a0 is implicit, so the a banks start at tap 1.
    logic signed [NC-1:0] r_sh_b  [0:ORDER];
    logic signed [NC-1:0] r_sh_a  [1:ORDER];
    logic signed [NC-1:0] r_act_b [0:ORDER];
    logic signed [NC-1:0] r_act_a [1:ORDER];
    logic signed [NC-1:0] w_nsh_b [0:ORDER];
    logic signed [NC-1:0] w_nsh_a [1:ORDER];

    logic signed [ACCW-1:0] w_acc;
    logic signed [NB-1:0]   w_y;
    logic signed [NB-1:0]   r_dout;
    logic                   r_vout;

    // Full-precision product, sign-extended to accumulator width.
    function automatic logic signed [ACCW-1:0] mac_term(
        input logic signed [NC-1:0] c,
        input logic signed [NB-1:0] s
    );
        logic signed [PW-1:0] p;
        p = $signed({{NB{c[NC-1]}}, c}) * $signed({{NC{s[NB-1]}}, s});
        return {{(ACCW-PW){p[PW-1]}}, p};
    endfunction

    // Shadow bank next state; the commit copies this so a same-cycle write
    // lands in the active bank too. Writes to a0 or past ORDER match no tap.
    always_comb begin
        w_nsh_b = r_sh_b;
        w_nsh_a = r_sh_a;
        for (int k = 0; k <= ORDER; k++) begin
            if (bus.COEF_WE && bus.COEF_SEL == COEF_SEL_B && bus.COEF_IDX == IW'(k)) begin
                w_nsh_b[k] = bus.COEF_DATA;
            end
        end
        for (int k = 1; k <= ORDER; k++) begin
            if (bus.COEF_WE && bus.COEF_SEL == COEF_SEL_A && bus.COEF_IDX == IW'(k)) begin
                w_nsh_a[k] = bus.COEF_DATA;
            end
        end
    end

    // CLR masks the history so a CLR+VIN sample sees only x[n]=DIN.
    always_comb begin
        w_acc = mac_term(r_act_b[0], bus.DIN);
        for (int k = 1; k <= ORDER; k++) begin
            w_acc = w_acc + mac_term(r_act_b[k], bus.CLR ? '0 : r_x[k])
                          - mac_term(r_act_a[k], bus.CLR ? '0 : r_y[k]);
        end
    end

    iir_round_sat #(
        .NB   (NB),
        .ACCW (ACCW),
        .FRAC (FRAC)
    ) u_round_sat (
        .i_acc  (w_acc),
        .o_dout (w_y)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_x     <= '{default: '0};
            r_y     <= '{default: '0};
            r_sh_b  <= '{default: '0};
            r_sh_a  <= '{default: '0};
            r_act_b <= '{default: '0};
            r_act_a <= '{default: '0};
            r_dout  <= '0;
            r_vout  <= 1'b0;
        end else begin
            r_sh_b <= w_nsh_b;
            r_sh_a <= w_nsh_a;
            if (bus.COEF_COMMIT) begin
                r_act_b <= w_nsh_b;
                r_act_a <= w_nsh_a;
            end

            r_vout <= bus.VIN;
            if (bus.VIN) begin
                r_dout <= w_y;
                r_x[1] <= bus.DIN;
                r_y[1] <= w_y;
                for (int k = 2; k <= ORDER; k++) begin
                    r_x[k] <= bus.CLR ? '0 : r_x[k-1];
                    r_y[k] <= bus.CLR ? '0 : r_y[k-1];
                end
            end else if (bus.CLR) begin
                r_x <= '{default: '0};
                r_y <= '{default: '0};
            end
        end
    end

    assign bus.DOUT = r_dout;
    assign bus.VOUT = r_vout;

endmodule

`default_nettype wire
